spike_encoder: RTL and testbench

//  Upstream stage of the SNN column layer: accepts one pixel volley per valid/ready handshake, converts intensities to spike times.

---
 rtl/spike_encoder_if.sv | 28 ++
 rtl/spike_encoder.sv | 143 ++++++++++++++
 tb/tb_spike_encoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spike_encoder_if.sv
// Pixel-volley input handshake plus the encoded spike-time output bus of spike_encoder.
// slave = encoder side, master = upstream/consumer side.
interface spike_encoder_if #(
  parameter int NUM_SPIKES      = 8,
  parameter int PIX_BITS        = 8,
  parameter int LOG_TIME_PERIOD = 3,
  parameter int CNT_BITS        = 16
);
  logic                                       in_valid;
  logic                                       in_ready;
  logic [NUM_SPIKES*PIX_BITS-1:0]             in_pixels;
  logic                                       in_train;
  logic [LOG_TIME_PERIOD:0]                   time_val;
  logic [NUM_SPIKES*(LOG_TIME_PERIOD+1)-1:0]  spike_times;
  logic                                       training;
  logic                                       volley_last;
  logic [CNT_BITS-1:0]                        volley_count;

  modport slave (
    input  in_valid, in_pixels, in_train,
    output in_ready, time_val, spike_times, training, volley_last, volley_count
  );

  modport master (
    output in_valid, in_pixels, in_train,
    input  in_ready, time_val, spike_times, training, volley_last, volley_count
  );
endinterface

// File: rtl/spike_encoder.sv
// Latency encoder: one pixel volley per handshake becomes one gamma cycle of spike times; 1-deep pending buffer.
// Accept -> time_val=0 two edges later; in_ready is registered and low while the pending buffer is full. Optional macro SPIKE_ENC_GAP_EN.
module spike_encoder #(
  parameter int NUM_SPIKES      = 8,
  parameter int PIX_BITS        = 8,
  parameter int LOG_TIME_PERIOD = 3,
  parameter int MIN_INTENSITY   = 32,
  parameter int CNT_BITS        = 16
) (
  input  logic               clk,
  input  logic               rst,
  spike_encoder_if.slave     bus
);
  localparam int TW = LOG_TIME_PERIOD + 1;
  localparam int SW = NUM_SPIKES * TW;
  localparam logic [TW-1:0]       T_IDLE   = TW'(1 << LOG_TIME_PERIOD);
  localparam logic [TW-1:0]       T_LAST   = TW'((1 << LOG_TIME_PERIOD) - 1);
  localparam logic [TW-1:0]       T_PRE    = TW'((1 << LOG_TIME_PERIOD) - 2);
  localparam logic [PIX_BITS-1:0] MIN_PIX  = PIX_BITS'(MIN_INTENSITY);
  localparam logic [TW-1:0]       NO_SPIKE = {1'b1, {LOG_TIME_PERIOD{1'b0}}};
  localparam logic [SW-1:0]       IDLE_ST  = {NUM_SPIKES{NO_SPIKE}};

`ifdef SPIKE_ENC_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;
`endif

  // Top LOG_TIME_PERIOD bits of ~p are exactly (~p) >> (PIX_BITS-LOG_TIME_PERIOD).
  function automatic logic [SW-1:0] encode(input logic [NUM_SPIKES*PIX_BITS-1:0] px);
    logic [PIX_BITS-1:0] p;
    encode = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      p = px[i*PIX_BITS +: PIX_BITS];
      if (p < MIN_PIX) encode[i*TW +: TW] = NO_SPIKE;
      else             encode[i*TW +: TW] = {1'b0, ~p[PIX_BITS-1 -: LOG_TIME_PERIOD]};
    end
  endfunction

  state_t              state_q;
  logic [TW-1:0]       time_q;
  logic [SW-1:0]       st_q;
  logic                tr_q;
  logic                last_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                rdy_q;
  logic                pend_vld_q, pend_vld_d;
  logic [SW-1:0]       pend_st_q;
  logic                pend_tr_q;
  logic                accept;
  logic                promote;

  assign accept = bus.in_valid & rdy_q;

  always_comb begin
    promote = 1'b0;
    case (state_q)
      S_IDLE: promote = pend_vld_q;
`ifdef SPIKE_ENC_GAP_EN
      S_RUN:  promote = 1'b0;
      S_GAP:  promote = pend_vld_q;
`else
      S_RUN:  promote = pend_vld_q && (time_q == T_LAST);
`endif
      default: promote = 1'b0;
    endcase
  end

  // Promotion and acceptance may share an edge: the new volley refills the slot just vacated.
  assign pend_vld_d = accept | (pend_vld_q & ~promote);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_st_q  <= IDLE_ST;
      pend_tr_q  <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      rdy_q      <= ~pend_vld_d;
      if (accept) begin
        pend_st_q <= encode(bus.in_pixels);
        pend_tr_q <= bus.in_train;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      time_q  <= T_IDLE;
      st_q    <= IDLE_ST;
      tr_q    <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (time_q == T_LAST) begin
            cnt_q  <= cnt_q + 1'b1;
            last_q <= 1'b0;
            if (promote) begin
              time_q <= '0;
              st_q   <= pend_st_q;
              tr_q   <= pend_tr_q;
            end else begin
`ifdef SPIKE_ENC_GAP_EN
              state_q <= S_GAP;
`else
              state_q <= S_IDLE;
`endif
              time_q <= T_IDLE;
              st_q   <= IDLE_ST;
              tr_q   <= 1'b0;
            end
          end else begin
            time_q <= time_q + 1'b1;
            last_q <= (time_q == T_PRE);
          end
        end
        default: begin
          // IDLE and GAP both hold idle outputs and start a gamma cycle from a full pending slot.
          last_q <= 1'b0;
          if (promote) begin
            state_q <= S_RUN;
            time_q  <= '0;
            st_q    <= pend_st_q;
            tr_q    <= pend_tr_q;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready     = rdy_q;
  assign bus.time_val     = time_q;
  assign bus.spike_times  = st_q;
  assign bus.training     = tr_q;
  assign bus.volley_last  = last_q;
  assign bus.volley_count = cnt_q;
endmodule

// File: tb/tb_spike_encoder.sv
// Directed, table-driven bench for spike_encoder; a 3-bit-counter instance shadows the main one to exercise counter wrap.
module tb_spike_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spike_encoder_if #(.CNT_BITS(16)) bus ();
  spike_encoder_if #(.CNT_BITS(3))  sm ();

  spike_encoder #(.CNT_BITS(16)) dut    (.clk(clk), .rst(rst), .bus(bus));
  spike_encoder #(.CNT_BITS(3))  dut_sm (.clk(clk), .rst(rst), .bus(sm));

  assign sm.in_valid  = bus.in_valid;
  assign sm.in_pixels = bus.in_pixels;
  assign sm.in_train  = bus.in_train;

  typedef struct packed {
    logic [63:0] px;
    logic        train;
    logic [31:0] st;
  } vec_t;

  vec_t tbl [6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_exp  = 0;

  localparam logic [31:0] IDLE_ST = 32'h8888_8888;

  function automatic logic [63:0] px8(input int p0, p1, p2, p3, p4, p5, p6, p7);
    return {8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  function automatic logic [31:0] st8(input int e0, e1, e2, e3, e4, e5, e6, e7);
    return {4'(e7), 4'(e6), 4'(e5), 4'(e4), 4'(e3), 4'(e2), 4'(e1), 4'(e0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_time"}, 64'(bus.time_val), 64'd8);
    chk({name, "_st"},   64'(bus.spike_times), 64'(IDLE_ST));
    chk({name, "_tr"},   64'(bus.training), 64'd0);
    chk({name, "_last"}, 64'(bus.volley_last), 64'd0);
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_cnt"},    64'(bus.volley_count), 64'(cnt_exp[15:0]));
    chk({name, "_cnt_sm"}, 64'(sm.volley_count),  64'(cnt_exp[2:0]));
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.in_pixels = v.px;
    bus.in_train  = v.train;
    for (int k = 0; k < 40 && !bus.in_ready; k++) @(negedge clk);
    chk("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_pixels = '0;
    bus.in_train  = 1'b0;
  endtask

  task automatic wait_time(input logic [3:0] val);
    for (int k = 0; k < 60 && bus.time_val != val; k++) @(negedge clk);
    chk("wait_time_val", 64'(bus.time_val), 64'(val));
  endtask

  // Entered at the negedge showing time_val=0; leaves at the negedge after time_val=7.
  task automatic check_volley(input vec_t v, input logic rdy_mid);
    for (int t = 0; t < 8; t++) begin
      chk("vol_time", 64'(bus.time_val), 64'(t));
      chk("vol_st",   64'(bus.spike_times), 64'(v.st));
      chk("vol_tr",   64'(bus.training), 64'(v.train));
      chk("vol_last", 64'(bus.volley_last), (t == 7) ? 64'd1 : 64'd0);
      if (t == 4) chk("vol_ready_mid", 64'(bus.in_ready), 64'(rdy_mid));
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0] = '{px: px8(255, 200, 100, 32, 31, 10, 0, 128), train: 1'b1, st: st8(0, 1, 4, 6, 8, 8, 8, 3)};
    tbl[1] = '{px: px8(31, 32, 255, 64, 63, 96, 224, 160), train: 1'b0, st: st8(8, 6, 0, 5, 6, 4, 0, 2)};
    tbl[2] = '{px: px8(0, 0, 0, 0, 0, 0, 0, 0),            train: 1'b1, st: st8(8, 8, 8, 8, 8, 8, 8, 8)};
    tbl[3] = '{px: px8(33, 65, 97, 129, 161, 193, 225, 254), train: 1'b0, st: st8(6, 5, 4, 3, 2, 1, 0, 0)};
    tbl[4] = '{px: px8(191, 127, 50, 30, 250, 90, 140, 70), train: 1'b1, st: st8(2, 4, 6, 8, 0, 5, 3, 5)};
    tbl[5] = '{px: px8(255, 255, 255, 255, 255, 255, 255, 255), train: 1'b0, st: st8(0, 0, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pixels = '0;
    bus.in_train  = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_ready", 64'(bus.in_ready), 64'd0);
    chk_counts("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Reset at time_val=4 with a pending volley: both must vanish.
    send(tbl[0]);
    chk("latency_idle_time", 64'(bus.time_val), 64'd8);
    chk("pending_full_ready", 64'(bus.in_ready), 64'd0);
    send(tbl[1]);
    wait_time(4'd4);
    chk("midreset_pend_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midreset");
    chk("midreset_ready", 64'(bus.in_ready), 64'd0);
    chk_counts("midreset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("after_midreset");
    chk("after_midreset_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i]);
      chk("tbl_latency_time", 64'(bus.time_val), 64'd8);
      @(negedge clk);
      check_volley(tbl[i], 1'b1);
      chk_idle("tbl_end");
      cnt_exp++;
      chk_counts("tbl_end");
    end

    // Three volleys with in_valid held: second waits in pending, third stalls.
    fork
      begin
        send(tbl[0]);
        send(tbl[3]);
        send(tbl[4]);
      end
      begin
        wait_time(4'd0);
        check_volley(tbl[0], 1'b0);
`ifdef SPIKE_ENC_GAP_EN
        chk_idle("gap1");
        @(negedge clk);
`endif
        cnt_exp++;
        chk_counts("b2b_first");
        check_volley(tbl[3], 1'b0);
`ifdef SPIKE_ENC_GAP_EN
        chk_idle("gap2");
        @(negedge clk);
`endif
        check_volley(tbl[4], 1'b1);
        chk_idle("b2b_end");
        cnt_exp += 2;
        chk_counts("b2b_end");
      end
    join

    repeat (3) @(negedge clk);
    chk_idle("final");
    chk_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
